// File: rtl/dr_uart_tx_if.sv
// Debug-register word strobe in, UART line and status out.
// master drives dr_in/dr_valid; slave is the transmitter.
interface dr_uart_tx_if;
    logic [31:0] dr_in;
    logic        dr_valid;
    logic        txd;
    logic        busy;
    logic        overrun;

    modport master (
        output dr_in,
        output dr_valid,
        input  txd,
        input  busy,
        input  overrun
    );

    modport slave (
        input  dr_in,
        input  dr_valid,
        output txd,
        output busy,
        output overrun
    );
endinterface

// File: rtl/dr_uart_tx.sv
// Serialises each strobed 32-bit debug word as 8 uppercase hex chars + CR LF over 8N1 UART.
// Latency: start bit begins 1 cycle after dr_valid; one word takes 100*CLKS_PER_BIT cycles.
// Backpressure: none; one-deep pending buffer, newest word wins and sets sticky overrun.
module dr_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    dr_uart_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [31:0] word;
    logic [31:0] pend;
    logic        pend_v;
    logic        txd_q;
    logic        overrun_q;
    logic [3:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;

    logic [3:0]  nib;
    logic [7:0]  cur_byte;
    logic        bit_tick;
    logic        final_done;

    always_comb begin
        nib = word[5'd28 - {byte_idx[2:0], 2'b00} +: 4];
        if (byte_idx == 4'd8)
            cur_byte = 8'h0D;
        else if (byte_idx == 4'd9)
            cur_byte = 8'h0A;
        else if (nib < 4'd10)
            cur_byte = {4'h3, nib};
        else
            cur_byte = 8'h37 + {4'h0, nib};
    end

    assign bit_tick   = (baud_cnt == 16'(CLKS_PER_BIT - 1));
    assign final_done = (state == STOP) && bit_tick && (byte_idx == 4'd9);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            word      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            txd_q     <= 1'b1;
            overrun_q <= 1'b0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            // The frame-end cycle handles its own strobe below so no overrun is flagged there.
            if (bus.dr_valid && (state != IDLE) && !final_done) begin
                pend   <= bus.dr_in;
                pend_v <= 1'b1;
                if (pend_v)
                    overrun_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (bus.dr_valid) begin
                        word     <= bus.dr_in;
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        txd_q    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_q    <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        if (byte_idx != 4'd9) begin
                            byte_idx <= byte_idx + 4'd1;
                            txd_q    <= 1'b0;
                            state    <= START;
                        end else if (pend_v || bus.dr_valid) begin
                            // Chain straight into the next word with no idle bit time.
                            if (pend_v) begin
                                word   <= pend;
                                pend_v <= bus.dr_valid;
                                if (bus.dr_valid)
                                    pend <= bus.dr_in;
                            end else begin
                                word <= bus.dr_in;
                            end
                            byte_idx <= '0;
                            txd_q    <= 1'b0;
                            state    <= START;
                        end else begin
                            txd_q <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txd     = txd_q;
    assign bus.busy    = (state != IDLE) | pend_v;
    assign bus.overrun = overrun_q;

endmodule

// File: doc/dr_uart_tx.md
Name: dr_uart_tx

Overview:
- Host-facing consumer of the CPU debug register value written by the CPDR instruction.
- Captures a 32-bit value on a one-cycle strobe and transmits it as 8 uppercase ASCII hex characters followed by CR LF, over an 8N1 UART line.
- Sits beside the CPU core on the board, between the core's debug-register output and the FPGA TX pin.
- Provides a one-deep pending buffer so back-to-back CPDR writes are not lost.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- dr_in  input  32  debug register value to send.
- dr_valid  input  1  one-cycle strobe: dr_in valid this cycle.
- txd  output  1  UART serial out; idle high.
- busy  output  1  high while a frame is in progress or a word is pending.
- overrun  output  1  sticky: a pending word was overwritten.

Behaviour:
- Reset (reset=0, asynchronous):
  - txd=1, busy=0, overrun=0.
  - state=IDLE; pending valid cleared; all counters 0.
  - Takes effect immediately, including mid-bit or mid-frame; the partial frame is abandoned and not resumed.
- Frame format:
  - 10 bytes per word: hex digits of dr_in[31:28] down to dr_in[3:0], then 0x0D, 0x0A.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
- Byte format:
  - Start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit held exactly CLKS_PER_BIT cycles.
  - Bytes within a word are back-to-back with no idle gap.
  - One word = 10*10*CLKS_PER_BIT cycles.
- Registers:
  - word[31:0]: word being sent.
  - pend[31:0] and pend_v: pending buffer.
  - byte_idx 0..9; bit_idx 0..7; baud counter 0..CLKS_PER_BIT-1.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: on dr_valid, word<=dr_in, byte_idx<=0, go to START. txd drives 0 from the next cycle, so latency from strobe to start-bit edge is 1 cycle.
  - START: after CLKS_PER_BIT cycles, go to DATA with bit_idx=0.
  - DATA: shift out bit bit_idx of the current byte. After bit 7 has been held CLKS_PER_BIT cycles, go to STOP.
  - STOP: after CLKS_PER_BIT cycles:
    - if byte_idx<9: byte_idx++, go to START.
    - else if pend_v: word<=pend, pend_v<=0, byte_idx<=0, go to START.
    - else go to IDLE.
- Strobe while not IDLE:
  - If pend_v=0: pend<=dr_in, pend_v<=1.
  - If pend_v=1: pend<=dr_in (newest wins), overrun<=1.
- Simultaneous events:
  - dr_valid in the same cycle the final STOP completes with pend_v=1: pend is moved to word, then dr_in goes to pend with pend_v=1, and overrun is not set.
  - dr_valid in the same cycle the final STOP completes with pend_v=0: dr_in is loaded directly into word; no idle cycle on the line.
- Current byte is selected combinationally from word and byte_idx; no extra pipeline stage.
- busy = (state!=IDLE) | pend_v. busy falls in the cycle the line returns to IDLE with no pending word.
- overrun clears only on reset.
- dr_in is sampled only on cycles where dr_valid=1; changes at other times have no effect.

Test Plan:
- CLKS_PER_BIT=4; release reset; pulse dr_valid with dr_in=0x0000_00FF:
  - txd falls on the next cycle.
  - Decoded bytes: "000000FF" then 0x0D 0x0A.
  - Total 400 cycles; busy drops afterwards; overrun=0.
- dr_in=0xDEAD_BEEF:
  - Decoded bytes: 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46,0x0D,0x0A.
  - Each bit exactly 4 cycles, LSB first; stop bits high.
- Strobe 0x1234_5678, then 0x9ABC_DEF0 at cycle 50:
  - Both words sent back-to-back (800 cycles), no gap between the last LF and the next start bit.
  - overrun=0.
- Strobe 0x1, then 0x2 at cycle 20, then 0x3 at cycle 30:
  - Line carries "00000001" then "00000003".
  - overrun=1 from cycle 31 and stays set.
- Pulse dr_valid exactly in the final STOP-completion cycle of a frame with a pending word: pending word is sent next, strobed word after it, overrun=0.
- Assert reset at cycle 150 of a frame:
  - txd=1, busy=0 with no clock edge needed.
  - After release the line stays idle until a new strobe, which sends a complete, correct frame.
